mem_port_arbiter: RTL and testbench

Arbitrates the single program/data memory port between the CPU control sequencer (fetch and operand cycles) and the front-panel program loader. Grants one owner per cycle and muxes address, write data and write-enable onto the memory. Routes synchronous read data back to the owner with a valid strobe. Raises a stall to the sequencer when the CPU is denied, with starvation protection for the loader and bounded loader bursts.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between the CPU sequencer and the front-panel loader.
// One owner per cycle, combinational address/data mux, registered read-return strobes.
module mem_port_arbiter #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 7,
    parameter int LOCK_MAX = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    input  logic              ldr_req,
    input  logic              ldr_lock,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);
    localparam logic [3:0] BURST_SAT  = 4'(LOCK_MAX);
    localparam logic [3:0] BURST_LAST = 4'(LOCK_MAX - 1);

    owner_t     r_owner;
    owner_t     w_owner_next;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_next;
    logic [3:0] r_burst_cnt;
    logic [3:0] w_burst_next;
    logic       r_cpu_rvalid;
    logic       r_ldr_rvalid;
    logic       w_cpu_xfer;
    logic       w_ldr_xfer;
    logic       w_ldr_keep;
    logic       w_unused_rdata;

    // Read data goes straight from memory to both masters; the rvalid strobes tag its owner.
    assign w_unused_rdata = ^mem_rdata;

    assign w_cpu_xfer = cpu_req & (r_owner == OWN_CPU);
    assign w_ldr_xfer = ldr_req & (r_owner == OWN_LDR);

    // burst_cnt counts completed locked transfers, so the current one is the last when it hits LOCK_MAX-1.
    assign w_ldr_keep = ldr_req & ldr_lock & (r_burst_cnt < BURST_LAST);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_owner <= OWN_IDLE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    always_comb begin
        w_owner_next = OWN_IDLE;
        case (r_owner)
            OWN_IDLE: begin
                if (cpu_req)      w_owner_next = OWN_CPU;
                else if (ldr_req) w_owner_next = OWN_LDR;
                else              w_owner_next = OWN_IDLE;
            end
            OWN_CPU: begin
                if (ldr_req && (r_wait_cnt == WAIT_LIMIT)) w_owner_next = OWN_LDR;
                else if (cpu_req)                          w_owner_next = OWN_CPU;
                else if (ldr_req)                          w_owner_next = OWN_LDR;
                else                                       w_owner_next = OWN_IDLE;
            end
            OWN_LDR: begin
                if (w_ldr_keep)   w_owner_next = OWN_LDR;
                else if (cpu_req) w_owner_next = OWN_CPU;
                else if (ldr_req) w_owner_next = OWN_LDR;
                else              w_owner_next = OWN_IDLE;
            end
            default: w_owner_next = OWN_IDLE;
        endcase
    end

    always_comb begin
        cpu_gnt   = (r_owner == OWN_CPU);
        ldr_gnt   = (r_owner == OWN_LDR);
        cpu_stall = cpu_req & ~cpu_gnt;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_cpu_xfer) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (w_ldr_xfer) begin
            mem_en    = 1'b1;
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (!ldr_req || (w_owner_next == OWN_LDR)) begin
            w_wait_next = '0;
        end else if ((r_owner != OWN_LDR) && (r_wait_cnt < WAIT_LIMIT)) begin
            w_wait_next = r_wait_cnt + 4'd1;
        end
    end

    always_comb begin
        w_burst_next = r_burst_cnt;
        if ((r_owner != OWN_LDR) || (w_owner_next != OWN_LDR)) begin
            w_burst_next = '0;
        end else if (w_ldr_xfer) begin
            if (!ldr_lock)                    w_burst_next = '0;
            else if (r_burst_cnt < BURST_SAT) w_burst_next = r_burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wait_cnt   <= '0;
            r_burst_cnt  <= '0;
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
        end else begin
            r_wait_cnt   <= w_wait_next;
            r_burst_cnt  <= w_burst_next;
            r_cpu_rvalid <= w_cpu_xfer & ~cpu_we;
            r_ldr_rvalid <= w_ldr_xfer & ~ldr_we;
        end
    end

    assign cpu_rvalid = r_cpu_rvalid;
    assign ldr_rvalid = r_ldr_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small synchronous memory sits on the port and
// expected read data is queued per master and checked when its rvalid strobe arrives.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       clr;
    logic       cpu_req, cpu_we;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid;
    logic       ldr_req, ldr_lock, ldr_we;
    logic [3:0] ldr_addr;
    logic [7:0] ldr_wdata;
    logic       ldr_gnt, ldr_rvalid;
    logic       mem_en, mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       preload;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem     [16];
    logic [7:0] exp_mem [16];
    logic [7:0] cpu_q [$];
    logic [7:0] ldr_q [$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(4), .DATA_W(8), .MAX_WAIT(7), .LOCK_MAX(15)
    ) dut (
        .clk(clk), .clr(clr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .ldr_req(ldr_req), .ldr_lock(ldr_lock), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 29 + 7);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 16; a++) mem[a] <= pat(a);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Read-return scoreboard
    always @(negedge clk) begin
        if (cpu_rvalid || ldr_rvalid) chk("rvalid_exclusive", cpu_rvalid & ldr_rvalid, 0);
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", cpu_rvalid, 0);
            else begin
                mon_exp = cpu_q.pop_front();
                chk("cpu_rdata", mem_rdata, mon_exp);
            end
        end
        if (ldr_rvalid) begin
            if (ldr_q.size() == 0) chk("ldr_rvalid_unexpected", ldr_rvalid, 0);
            else begin
                mon_exp = ldr_q.pop_front();
                chk("ldr_rdata", mem_rdata, mon_exp);
            end
        end
    end

    initial begin
        clr = 1'b0; preload = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_lock = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        for (int a = 0; a < 16; a++) exp_mem[a] = pat(a);

        // Reset state
        go(); go();
        preload = 1'b0;
        settle();
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ldr_gnt", ldr_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_ldr_rvalid", ldr_rvalid, 0);
        go(); cpu_req = 1; #1;
        chk("rst_stall_follows_req", cpu_stall, 1);
        chk("rst_cpu_gnt_held", cpu_gnt, 0);
        go(); cpu_req = 0; clr = 1'b1;
        settle();
        chk("release_idle", cpu_gnt | ldr_gnt, 0);

        // CPU alone: five request cycles, four reads
        go(); cpu_req = 1; cpu_we = 0; cpu_addr = 0;
        settle();
        chk("t1_c0_gnt", cpu_gnt, 0);
        chk("t1_c0_stall", cpu_stall, 1);
        chk("t1_c0_mem_en", mem_en, 0);
        for (int i = 1; i <= 4; i++) begin
            go(); cpu_addr = 4'(i); cpu_q.push_back(exp_mem[i]);
            settle();
            chk("t1_gnt", cpu_gnt, 1);
            chk("t1_stall", cpu_stall, 0);
            chk("t1_mem_en", mem_en, 1);
            chk("t1_mem_we", mem_we, 0);
            chk("t1_mem_addr", mem_addr, i);
            chk("t1_rvalid", cpu_rvalid, (i >= 2) ? 1 : 0);
        end
        go(); cpu_req = 0;
        settle();
        chk("t1_wasted_mem_en", mem_en, 0);
        chk("t1_last_rvalid", cpu_rvalid, 1);
        go(); settle();
        chk("t1_idle_gnt", cpu_gnt, 0);
        chk("t1_idle_rvalid", cpu_rvalid, 0);

        // CPU drops its request for one cycle
        go(); cpu_req = 1; cpu_addr = 1;
        settle(); chk("t6_first_gnt", cpu_gnt, 0);
        go(); cpu_q.push_back(exp_mem[1]);
        settle(); chk("t6_gnt", cpu_gnt, 1); chk("t6_mem_en", mem_en, 1);
        go(); cpu_req = 0;
        settle(); chk("t6_drop_gnt", cpu_gnt, 1); chk("t6_drop_mem_en", mem_en, 0);
        go(); cpu_req = 1;
        settle(); chk("t6_idle_gnt", cpu_gnt, 0); chk("t6_idle_stall", cpu_stall, 1);
        chk("t6_idle_mem_en", mem_en, 0);
        go(); cpu_q.push_back(exp_mem[1]);
        settle(); chk("t6_regnt", cpu_gnt, 1); chk("t6_regnt_mem_en", mem_en, 1);
        go(); cpu_req = 0;
        go(); settle();

        // Tie in IDLE, loader starves until wait_cnt hits MAX_WAIT, then writes 0x3C to 0x5
        go(); cpu_req = 1; cpu_addr = 2;
        ldr_req = 1; ldr_we = 1; ldr_lock = 0; ldr_addr = 5; ldr_wdata = 8'h3C;
        settle(); chk("t2_c0_cpu_gnt", cpu_gnt, 0); chk("t2_c0_ldr_gnt", ldr_gnt, 0);
        for (int c = 1; c <= 7; c++) begin
            go(); cpu_q.push_back(exp_mem[2]);
            settle(); chk("t2_cpu_gnt", cpu_gnt, 1); chk("t2_ldr_denied", ldr_gnt, 0);
        end
        go(); exp_mem[5] = 8'h3C;
        settle();
        chk("t2_c8_ldr_gnt", ldr_gnt, 1);
        chk("t2_c8_cpu_gnt", cpu_gnt, 0);
        chk("t2_c8_stall", cpu_stall, 1);
        chk("t2_c8_mem_we", mem_we, 1);
        chk("t2_c8_mem_addr", mem_addr, 5);
        chk("t2_c8_mem_wdata", mem_wdata, 8'h3C);
        go(); ldr_req = 0; cpu_addr = 5; cpu_q.push_back(exp_mem[5]);
        settle(); chk("t4_cpu_gnt", cpu_gnt, 1); chk("t4_mem_we", mem_we, 0);
        chk("t4_mem_addr", mem_addr, 5);
        go(); cpu_req = 0;
        settle();
        chk("t4_cpu_rvalid", cpu_rvalid, 1);
        chk("t4_ldr_rvalid", ldr_rvalid, 0);
        chk("t4_rdata", mem_rdata, 8'h3C);
        go(); settle();

        // Locked loader burst against a requesting CPU
        go(); ldr_req = 1; ldr_lock = 1; ldr_we = 1; ldr_addr = 0; ldr_wdata = 8'h5A;
        settle(); chk("t3_c0_ldr_gnt", ldr_gnt, 0); chk("t3_c0_mem_en", mem_en, 0);
        for (int k = 0; k < 15; k++) begin
            go(); cpu_req = 1; cpu_addr = 3;
            ldr_addr = 4'(k); ldr_wdata = 8'(k) ^ 8'hA5; exp_mem[k] = 8'(k) ^ 8'hA5;
            settle();
            chk("t3_ldr_gnt", ldr_gnt, 1);
            chk("t3_cpu_stall", cpu_stall, 1);
            chk("t3_mem_we", mem_we, 1);
            chk("t3_mem_addr", mem_addr, k);
            chk("t3_mem_wdata", mem_wdata, 8'(k) ^ 8'hA5);
        end
        go(); ldr_req = 0; ldr_lock = 0; cpu_q.push_back(exp_mem[3]);
        settle(); chk("t3_end_ldr_gnt", ldr_gnt, 0); chk("t3_end_cpu_gnt", cpu_gnt, 1);
        go(); cpu_req = 0;
        go(); settle();

        // Reset pulsed the cycle after a loader read
        go(); ldr_req = 1; ldr_lock = 1; ldr_we = 0; ldr_addr = 3;
        settle(); chk("t5_c0_ldr_gnt", ldr_gnt, 0);
        go(); ldr_q.push_back(exp_mem[3]);
        settle(); chk("t5_ldr_gnt", ldr_gnt, 1); chk("t5_mem_en", mem_en, 1);
        go(); clr = 1'b0; ldr_q.delete(); #1;
        chk("t5_rst_ldr_gnt", ldr_gnt, 0);
        chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_ldr_rvalid", ldr_rvalid, 0);
        chk("t5_rst_owner", dut.r_owner, 0);
        go(); clr = 1'b1;
        settle();
        chk("t5_wait_cnt", dut.r_wait_cnt, 0);
        chk("t5_burst_cnt", dut.r_burst_cnt, 0);
        chk("t5_release_ldr_gnt", ldr_gnt, 0);
        go(); ldr_q.push_back(exp_mem[3]);
        settle(); chk("t5_regnt", ldr_gnt, 1);
        go(); ldr_req = 0; ldr_lock = 0;
        settle(); chk("t5_ldr_rvalid", ldr_rvalid, 1);
        go(); settle();

        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("ldr_q_drained", ldr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
